// File: rtl/acc_pkg.sv
// Shared constants and types for the ofmap write-back path.
package acc_pkg;
  localparam int LANES       = 4;
  localparam int DW          = 16;
  localparam int AW          = 13;
  localparam int FIFO_DEPTH  = 8;
  localparam int FRAME_WORDS = 480;
  localparam int STARVE_LIM  = 3;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef logic [DW-1:0] fp16_t;
endpackage

// File: rtl/ofmap_wb_arbiter_if.sv
// Group push and host read handshakes of the write-back arbiter.
interface ofmap_wb_arbiter_if;
  import acc_pkg::*;

  logic                grp_valid;
  logic                grp_ready;
  logic [LANES*DW-1:0] grp_data;
  logic                host_rd_req;
  logic [AW-1:0]       host_rd_addr;
  logic                host_rd_gnt;
  logic                host_rd_vld;
  logic [31:0]         host_rd_data;

  modport master (
    output grp_valid, grp_data,
    output host_rd_req, host_rd_addr,
    input  grp_ready, host_rd_gnt,
    input  host_rd_vld, host_rd_data
  );

  modport slave (
    input  grp_valid, grp_data,
    input  host_rd_req, host_rd_addr,
    output grp_ready, host_rd_gnt,
    output host_rd_vld, host_rd_data
  );
endinterface

// File: rtl/ofmap_wb_fifo.sv
// Word FIFO: LANES words pushed per group, one word popped per cycle.
module ofmap_wb_fifo
  import acc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                push,
  input  logic [LANES*DW-1:0] push_data,
  input  logic                pop,
  output fp16_t               head,
  output logic [LW-1:0]       level
);

  fp16_t         mem_q [FIFO_DEPTH];
  fp16_t         mem_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) begin
        for (int k = 0; k < LANES; k++)
          mem_d[wptr_q + PW'(k)] = push_data[k*DW +: DW];
        wptr_d = wptr_q + PW'(LANES);
      end
      if (pop)
        rptr_d = rptr_q + 1'b1;
      level_d = level_q
              + (push ? LW'(LANES) : LW'(0))
              - (pop  ? LW'(1)     : LW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign head  = mem_q[rptr_q];
  assign level = level_q;

endmodule

// File: rtl/ofmap_wb_arbiter.sv
// Output SRAM write-back scheduler: FIFO drain vs host reads,
// bounded host priority, frame address wrap.
module ofmap_wb_arbiter
  import acc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_clr,
  ofmap_wb_arbiter_if.slave  bus,
  output logic               sram_en,
  output logic               sram_we,
  output logic [AW-1:0]      sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic [AW-1:0]      wr_addr,
  output logic               frame_done,
  output logic [LW-1:0]      fifo_level
);

  fp16_t         head;
  logic          fifo_empty;
  logic          host_gnt;
  logic          wr_en;
  logic          push;
  logic          at_end;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          frame_done_q, frame_done_d;
  logic          rd_vld_q, rd_vld_d;
  logic [31:0]   rd_hold_q, rd_hold_d;

  ofmap_wb_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (frame_clr),
    .push      (push),
    .push_data (bus.grp_data),
    .pop       (wr_en),
    .head      (head),
    .level     (fifo_level)
  );

  // ready is withheld during clr so a dropped group is never handshaken
  assign fifo_empty = (fifo_level == '0);
  assign bus.grp_ready = !rst && !frame_clr
                       && (fifo_level <= LW'(FIFO_DEPTH - LANES));
  assign push = bus.grp_valid && bus.grp_ready;

  assign host_gnt = !rst && bus.host_rd_req
                  && (fifo_empty
                      || starve_cnt_q < SW'(STARVE_LIM));
  assign wr_en = !rst && !frame_clr && !host_gnt && !fifo_empty;
  assign at_end = (wr_addr_q == AW'(FRAME_WORDS - 1));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (frame_clr || wr_en)
      starve_cnt_d = '0;
    else if (host_gnt && fifo_empty)
      starve_cnt_d = '0;
    else if (host_gnt)
      starve_cnt_d = starve_cnt_q + 1'b1;

    wr_addr_d = wr_addr_q;
    if (frame_clr)
      wr_addr_d = '0;
    else if (wr_en)
      wr_addr_d = at_end ? '0 : wr_addr_q + 1'b1;

    frame_done_d = wr_en && at_end;
    rd_vld_d     = host_gnt;
    rd_hold_d    = rd_vld_q ? sram_rdata : rd_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_hold_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
      rd_vld_q     <= rd_vld_d;
      rd_hold_q    <= rd_hold_d;
    end
  end

  assign sram_en    = host_gnt || wr_en;
  assign sram_we    = wr_en;
  assign sram_addr  = host_gnt ? bus.host_rd_addr : wr_addr_q;
  assign sram_wdata = {16'h0, head};

  // data follows SRAM output in the vld cycle, then holds
  assign bus.host_rd_gnt  = host_gnt;
  assign bus.host_rd_vld  = rd_vld_q;
  assign bus.host_rd_data = rd_vld_q ? sram_rdata : rd_hold_q;

  assign wr_addr    = wr_addr_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ofmap_wb_arbiter.sv
// Bench for ofmap_wb_arbiter: vector table, corner sequences,
// random traffic against a queue-level reference model.
module tb_ofmap_wb_arbiter;
  import acc_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_clr = 1'b0;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic [AW-1:0] wr_addr;
  logic          frame_done;
  logic [LW-1:0] fifo_level;

  ofmap_wb_arbiter_if bus();

  ofmap_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .frame_clr  (frame_clr),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .wr_addr    (wr_addr),
    .frame_done (frame_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [8192];

  always @(posedge clk) begin
    if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
  end

  function automatic logic [31:0] pre(input logic [AW-1:0] a);
    return {3'b101, a, 16'h5A5A};
  endfunction

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // reference model state
  fp16_t         q[$];
  int            starve = 0;
  int            waddr = 0;
  bit            pend_vld = 0;
  bit            pend_done = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [31:0]   last_data = '0;
  int            groups = 0;
  int            dut_writes = 0;
  int            done_cnt = 0;

  // samples of the last step
  logic          s_en, s_we, s_vld, s_done, s_rdy;
  logic [AW-1:0] s_addr, s_wraddr;
  logic [31:0]   s_wdata, s_data;
  logic [LW-1:0] s_level;

  task automatic step(input bit r, input bit req,
                      input logic [AW-1:0] ra, input bit gv,
                      input logic [63:0] gd, input bit clr);
    bit e_rdy, e_gnt, e_wr, e_push;
    @(negedge clk);
    rst = r;
    frame_clr = clr;
    bus.host_rd_req = req;
    bus.host_rd_addr = ra;
    bus.grp_valid = gv;
    bus.grp_data = gd;
    #1;
    e_rdy = !r && !clr && q.size() <= FIFO_DEPTH - LANES;
    e_gnt = !r && req && (q.size() == 0 || starve < STARVE_LIM);
    e_wr = !r && !clr && !e_gnt && q.size() > 0;
    e_push = gv && e_rdy;
    if (pend_vld) last_data = pre(pend_addr);
    s_en = sram_en; s_we = sram_we; s_addr = sram_addr;
    s_wdata = sram_wdata; s_level = fifo_level;
    s_vld = bus.host_rd_vld; s_data = bus.host_rd_data;
    s_done = frame_done; s_wraddr = wr_addr; s_rdy = bus.grp_ready;
    chk("grp_ready", s_rdy, e_rdy);
    chk("host_rd_gnt", bus.host_rd_gnt, e_gnt);
    chk("sram_en", s_en, e_gnt || e_wr);
    if (e_gnt || e_wr) chk("sram_we", s_we, e_wr);
    if (e_gnt) chk("rd_sram_addr", s_addr, ra);
    if (e_wr) begin
      chk("wr_sram_addr", s_addr, waddr);
      chk("sram_wdata", s_wdata, {16'h0, q[0]});
    end
    chk("fifo_level", s_level, q.size());
    chk("wr_addr", s_wraddr, waddr);
    chk("host_rd_vld", s_vld, pend_vld);
    chk("host_rd_data", s_data, last_data);
    chk("frame_done", s_done, pend_done);
    if (s_done === 1'b1) done_cnt++;
    if (s_en === 1'b1 && s_we === 1'b1) dut_writes++;
    pend_vld = e_gnt;
    pend_addr = ra;
    pend_done = e_wr && waddr == FRAME_WORDS - 1;
    if (r) begin
      q.delete(); waddr = 0; starve = 0; last_data = '0;
    end else if (clr) begin
      q.delete(); waddr = 0; starve = 0;
    end else begin
      if (e_wr) begin
        void'(q.pop_front());
        waddr = (waddr + 1) % FRAME_WORDS;
        starve = 0;
      end else if (e_gnt) begin
        starve = (q.size() == 0) ? 0 : starve + 1;
      end
      if (e_push) begin
        for (int k = 0; k < LANES; k++) q.push_back(gd[k*DW +: DW]);
        groups++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && q.size() > 0; i++)
      step(0, 0, '0, 0, '0, 0);
    chk("drain_bound", q.size(), 0);
  endtask

  typedef struct {
    bit            req;
    logic [AW-1:0] ra;
    bit            gv;
    logic [63:0]   gd;
    bit            en;
    bit            we;
    logic [AW-1:0] addr;
    logic [15:0]   word;
  } vec_t;

  function automatic vec_t mk(input bit req, input int ra, input bit gv,
                              input logic [63:0] gd, input bit en,
                              input bit we, input int addr,
                              input logic [15:0] w);
    vec_t v;
    v.req = req; v.ra = AW'(ra); v.gv = gv; v.gd = gd;
    v.en = en; v.we = we; v.addr = AW'(addr); v.word = w;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[16];
    logic [63:0] g1, g2;
    int g0, w0, guard;
    bit saw_stall;

    g1 = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
    g2 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tbl[0]  = mk(0, 0,    1, g1, 0, 0, 0, 16'h0);
    tbl[1]  = mk(0, 0,    0, 0,  1, 1, 0, 16'h3C00);
    tbl[2]  = mk(0, 0,    0, 0,  1, 1, 1, 16'h4000);
    tbl[3]  = mk(0, 0,    0, 0,  1, 1, 2, 16'h4200);
    tbl[4]  = mk(0, 0,    0, 0,  1, 1, 3, 16'h4400);
    tbl[5]  = mk(0, 0,    1, g2, 0, 0, 0, 16'h0);
    tbl[6]  = mk(1, 4100, 0, 0,  1, 0, 4100, 16'h0);
    tbl[7]  = mk(1, 4101, 0, 0,  1, 0, 4101, 16'h0);
    tbl[8]  = mk(1, 4102, 0, 0,  1, 0, 4102, 16'h0);
    tbl[9]  = mk(1, 4103, 0, 0,  1, 1, 4, 16'h1111);
    tbl[10] = mk(1, 4103, 0, 0,  1, 0, 4103, 16'h0);
    tbl[11] = mk(1, 4104, 0, 0,  1, 0, 4104, 16'h0);
    tbl[12] = mk(0, 0,    0, 0,  1, 1, 5, 16'h2222);
    tbl[13] = mk(0, 0,    0, 0,  1, 1, 6, 16'h3333);
    tbl[14] = mk(0, 0,    0, 0,  1, 1, 7, 16'h4444);
    tbl[15] = mk(0, 0,    0, 0,  0, 0, 0, 16'h0);

    for (int i = 0; i < 8192; i++) mem[i] = pre(AW'(i));
    bus.grp_valid = 0; bus.grp_data = '0;
    bus.host_rd_req = 0; bus.host_rd_addr = '0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_vld", bus.host_rd_vld, 0);
    chk("rst_data", bus.host_rd_data, 0);
    chk("rst_done", frame_done, 0);

    // single group write-back, then bounded host priority
    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].req, tbl[i].ra, tbl[i].gv, tbl[i].gd, 0);
      chk($sformatf("tbl%0d_en", i), s_en, tbl[i].en);
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d_we", i), s_we, tbl[i].we);
        chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      end
      if (tbl[i].we)
        chk($sformatf("tbl%0d_wdata", i), s_wdata, {16'h0, tbl[i].word});
    end

    // back-pressure under constant host reads
    saw_stall = 0;
    for (int i = 0; i < 80; i++) begin
      step(0, 1, AW'(4096 + $urandom_range(0, 4095)), 1,
           {$urandom, $urandom}, 0);
      if (s_rdy === 1'b0) saw_stall = 1;
    end
    chk("stall_seen", saw_stall, 1);
    drain();

    // full frame: 120 groups, wrap and one frame_done
    step(0, 0, '0, 0, '0, 1);
    g0 = groups; w0 = dut_writes; done_cnt = 0;
    guard = 0;
    while (groups - g0 < 120 && guard < 1000) begin
      step(0, 0, '0, 1, {$urandom, $urandom}, 0);
      guard++;
    end
    chk("frame_groups", groups - g0, 120);
    drain();
    idle(2);
    chk("frame_writes", dut_writes - w0, 480);
    chk("frame_done_cnt", done_cnt, 1);
    chk("frame_wrap", s_wraddr, 0);
    step(0, 0, '0, 1, g1, 0);
    step(0, 0, '0, 0, '0, 0);
    chk("after_wrap_addr", s_addr, 0);
    chk("after_wrap_we", s_we, 1);
    drain();

    // frame_clr with level 6 and a group offered
    step(0, 0, '0, 1, g2, 0);
    step(0, 0, '0, 0, '0, 0);
    step(0, 0, '0, 1, g1, 0);
    step(0, 0, '0, 1, g2, 1);
    chk("clr_level_before", s_level, 6);
    chk("clr_ready", s_rdy, 0);
    step(0, 0, '0, 0, '0, 0);
    chk("clr_level", s_level, 0);
    chk("clr_wr_addr", s_wraddr, 0);
    chk("clr_no_write", s_en, 0);

    // rst mid-drain with a host read in flight
    step(0, 0, '0, 1, g2, 0);
    step(0, 0, '0, 0, '0, 0);
    step(0, 1, AW'(5000), 0, '0, 0);
    step(1, 0, '0, 0, '0, 0);
    step(0, 0, '0, 0, '0, 0);
    chk("rst_mid_en", s_en, 0);
    chk("rst_mid_vld", s_vld, 0);
    chk("rst_mid_data", s_data, 0);
    chk("rst_mid_level", s_level, 0);
    chk("rst_mid_wr_addr", s_wraddr, 0);
    chk("rst_mid_done", s_done, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
           AW'(4096 + $urandom_range(0, 4095)),
           $urandom_range(0, 99) < 60, {$urandom, $urandom},
           $urandom_range(0, 39) == 0);
    end
    drain();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
